// File: rtl/or16_accum.sv
// or16_accum: ORs a programmed number of upstream words into one summary word.
// A start command opens a frame of len words. Each word accepted over the
// in_valid/in_ready handshake is ORed into an accumulator. When the frame
// ends (last beat or flush), the summary word and the beat count are offered
// downstream over out_valid/out_ready. The summary stays held until it is taken.
// Handshake outputs and result outputs come straight from flops.
module or16_accum #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_nx_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nx_s;
    logic [CNT_W-1:0] remaining_r;
    logic [CNT_W-1:0] remaining_nx_s;
    logic [WIDTH-1:0] out_data_r;
    logic [WIDTH-1:0] out_data_nx_s;
    logic [CNT_W-1:0] out_count_r;
    logic [CNT_W-1:0] out_count_nx_s;
    logic             in_ready_r;
    logic             in_ready_nx_s;
    logic             out_valid_r;
    logic             out_valid_nx_s;
    logic             busy_r;
    logic             busy_nx_s;

    logic             beat_s;
    logic [WIDTH-1:0] acc_or_s;
    logic [CNT_W-1:0] count_inc_s;
    logic [CNT_W-1:0] remaining_dec_s;
    logic             last_beat_s;

    // A beat needs ACCUM and a valid word; in_ready_r is high only in ACCUM.
    assign beat_s          = in_valid & in_ready_r & (state_r == ST_ACCUM);
    assign acc_or_s        = acc_r | in_data;
    assign count_inc_s     = count_r + CNT_ONE;
    assign remaining_dec_s = remaining_r - CNT_ONE;
    assign last_beat_s     = beat_s & (remaining_r == CNT_ONE);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_nx_s     = state_r;
        acc_nx_s       = acc_r;
        count_nx_s     = count_r;
        remaining_nx_s = remaining_r;
        out_data_nx_s  = out_data_r;
        out_count_nx_s = out_count_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    acc_nx_s       = DATA_ZERO;
                    count_nx_s     = CNT_ZERO;
                    remaining_nx_s = len;
                    if (len != CNT_ZERO) begin
                        state_nx_s = ST_ACCUM;
                    end else begin
                        // An empty frame goes straight to DONE with a zero result.
                        state_nx_s     = ST_DONE;
                        out_data_nx_s  = DATA_ZERO;
                        out_count_nx_s = CNT_ZERO;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end

            ST_ACCUM: begin
                if (beat_s) begin
                    acc_nx_s       = acc_or_s;
                    count_nx_s     = count_inc_s;
                    remaining_nx_s = remaining_dec_s;
                end else begin
                    acc_nx_s       = acc_r;
                    count_nx_s     = count_r;
                    remaining_nx_s = remaining_r;
                end

                if (last_beat_s || flush) begin
                    // Capture the result on the way into DONE. A coincident beat is included.
                    state_nx_s     = ST_DONE;
                    out_data_nx_s  = beat_s ? acc_or_s : acc_r;
                    out_count_nx_s = beat_s ? count_inc_s : count_r;
                end else begin
                    state_nx_s = ST_ACCUM;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end

            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and then registered,
        // so they depend only on flops in the cycle where they are seen.
        in_ready_nx_s  = (state_nx_s == ST_ACCUM);
        out_valid_nx_s = (state_nx_s == ST_DONE);
        busy_nx_s      = (state_nx_s != ST_IDLE);
    end

    // State, datapath and output registers. Reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            acc_r       <= DATA_ZERO;
            count_r     <= CNT_ZERO;
            remaining_r <= CNT_ZERO;
            out_data_r  <= DATA_ZERO;
            out_count_r <= CNT_ZERO;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            acc_r       <= acc_nx_s;
            count_r     <= count_nx_s;
            remaining_r <= remaining_nx_s;
            out_data_r  <= out_data_nx_s;
            out_count_r <= out_count_nx_s;
            in_ready_r  <= in_ready_nx_s;
            out_valid_r <= out_valid_nx_s;
            busy_r      <= busy_nx_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_count = out_count_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_or16_accum.sv
// Directed, table-driven bench for or16_accum.
module tb_or16_accum;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_count;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    or16_accum #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]        len;
        int                n;
        logic [3:0][15:0]  w;
        bit                stall;
        bit                flush_last;
        logic [15:0]       exp_data;
        logic [7:0]        exp_cnt;
    } frame_t;

    frame_t tbl[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input frame_t f);
        start = 1'b1;
        len   = f.len;
        tick();
        start = 1'b0;
        if (f.len == 8'd0) begin
            check("empty_out_valid", {31'd0, out_valid}, 32'd1);
            check("empty_in_ready", {31'd0, in_ready}, 32'd0);
        end else begin
            check("start_in_ready", {31'd0, in_ready}, 32'd1);
            check("start_busy", {31'd0, busy}, 32'd1);
            for (int i = 0; i < f.n; i++) begin
                if (f.stall) begin
                    // Garbage word with in_valid low must not be consumed.
                    in_valid = 1'b0;
                    in_data  = 16'hDEAD;
                    tick();
                    check("stall_in_ready", {31'd0, in_ready}, 32'd1);
                end
                in_valid = 1'b1;
                in_data  = f.w[i];
                flush    = f.flush_last && (i == f.n - 1);
                tick();
                in_valid = 1'b0;
                flush    = 1'b0;
                in_data  = 16'h0000;
                if (i != f.n - 1) begin
                    check("mid_out_valid", {31'd0, out_valid}, 32'd0);
                end
            end
            check("done_out_valid", {31'd0, out_valid}, 32'd1);
            check("done_in_ready", {31'd0, in_ready}, 32'd0);
        end
        check("done_out_data", {16'd0, out_data}, {16'd0, f.exp_data});
        check("done_out_count", {24'd0, out_count}, {24'd0, f.exp_cnt});
        check("done_busy", {31'd0, busy}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_hold_data", {16'd0, out_data}, {16'd0, f.exp_data});
    endtask

    initial begin
        tbl[0] = '{len: 8'd0,  n: 0, w: {16'h0, 16'h0, 16'h0, 16'h0},
                   stall: 1'b0, flush_last: 1'b0, exp_data: 16'h0000, exp_cnt: 8'd0};
        tbl[1] = '{len: 8'd3,  n: 3, w: {16'h0, 16'h8000, 16'h0100, 16'h0001},
                   stall: 1'b0, flush_last: 1'b0, exp_data: 16'h8101, exp_cnt: 8'd3};
        tbl[2] = '{len: 8'd4,  n: 4, w: {16'hF000, 16'h0F00, 16'h00F0, 16'h000F},
                   stall: 1'b1, flush_last: 1'b0, exp_data: 16'hFFFF, exp_cnt: 8'd4};
        tbl[3] = '{len: 8'd10, n: 3, w: {16'h0, 16'h0300, 16'h0030, 16'h0003},
                   stall: 1'b0, flush_last: 1'b1, exp_data: 16'h0333, exp_cnt: 8'd3};
        tbl[4] = '{len: 8'd1,  n: 1, w: {16'h0, 16'h0, 16'h0, 16'hA5A5},
                   stall: 1'b0, flush_last: 1'b0, exp_data: 16'hA5A5, exp_cnt: 8'd1};

        rst_n = 1'b0; start = 1'b0; len = 8'd0; flush = 1'b0;
        in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a frame clears everything at once.
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'h00FF;
        tick();
        tick();
        in_valid = 1'b0;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_out_data", {16'd0, out_data}, 32'd0);
        check("async_rst_out_count", {24'd0, out_count}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        for (int t = 0; t < 5; t++) begin
            run_frame(tbl[t]);
        end

        // Downstream backpressure: result held, upstream and start ignored.
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'h1234;
        tick();
        in_data = 16'h0001;
        tick();
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_data = 16'hFFFF;
            start = 1'b1; len = 8'd7;
            tick();
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_data", {16'd0, out_data}, 32'h1235);
            check("bp_out_count", {24'd0, out_count}, 32'd2);
        end
        start = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_busy", {31'd0, busy}, 32'd0);
        tick();
        check("bp_no_restart", {31'd0, busy}, 32'd0);

        // Maximum length frame, single set bit at beat 200.
        start = 1'b1; len = 8'd255;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 255; i++) begin
            in_data = (i == 199) ? 16'h4000 : 16'h0000;
            tick();
            if (i == 253) begin
                check("max_early_valid", {31'd0, out_valid}, 32'd0);
            end
        end
        in_valid = 1'b0; in_data = 16'h0000;
        check("max_out_valid", {31'd0, out_valid}, 32'd1);
        check("max_out_data", {16'd0, out_data}, 32'h4000);
        check("max_out_count", {24'd0, out_count}, 32'd255);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("max_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/or16_accum.md
# or16_accum

Sequential OR-reduction stage that sits directly downstream of the 16-bit bitwise OR datapath and consumes its output word stream. After a `start` command it ORs together a programmed number of 16-bit words, presented over a valid/ready handshake, into one 16-bit summary word. It then presents that word, with a beat count, to the next stage over a second valid/ready handshake. Typical uses are building flag/mask summaries over a block of words and checking whether any bit was ever set across a frame.

## Interface

- `WIDTH`, 16, data word width.
- `CNT_W`, 8, width of the frame length and beat counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; begins a frame, sampled only in IDLE.
- `len`  in  CNT_W  number of words in the frame, sampled with `start`.
- `flush`  in  1  terminate the current frame early; honoured only in ACCUM.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block accepts a word this cycle.
- `in_data`  in  WIDTH  upstream word, normally the OR16 output.
- `out_valid`  out  1  summary word valid.
- `out_ready`  in  1  downstream accepts summary.
- `out_data`  out  WIDTH  OR of all accepted words in the frame.
- `out_count`  out  CNT_W  number of words accepted in the frame.
- `busy`  out  1  high in ACCUM and DONE.

## Operation

- States are IDLE, ACCUM and DONE. Encoding is free; the state is not visible except through the outputs.
- **IDLE:**
  - `in_ready`=0, `out_valid`=0, `busy`=0.
  - On `start`=1: `acc`←0, `count`←0, `remaining`←`len`.
  - If `len`≠0, go to ACCUM; if `len`==0, go to DONE (empty frame, `out_data`=0, `out_count`=0).
- **ACCUM:**
  - `in_ready`=1, `busy`=1.
  - A beat is accepted when `in_valid`&&`in_ready`. On a beat: `acc`←`acc`|`in_data`, `count`←`count`+1, `remaining`←`remaining`−1.
  - If a beat is accepted while `remaining`==1, go to DONE.
  - If `flush`=1, go to DONE. A beat accepted in the same cycle as `flush` is included in `acc` and `count`.
  - `start` is ignored.
- **DONE:**
  - `out_valid`=1, `out_data`=`acc`, `out_count`=`count`, `in_ready`=0, `busy`=1.
  - Outputs are held stable until `out_valid`&&`out_ready`, then go to IDLE.
  - `start` and `flush` are ignored.
- Width rules:
  - `len` is unsigned, range 0..2^CNT_W−1.
  - `count` never exceeds `len`, so no wrap can occur.
  - The OR is bitwise, with no carry.
- Data is never dropped. Upstream words presented outside ACCUM are not consumed (`in_ready`=0).
- `out_data` and `out_count` are driven from registers. Their values outside DONE are don't-care for the protocol, but they must equal the last frame's results (or 0 after reset).

## Timing

- Reset (`rst_n`=0, asynchronous) forces:
  - state to IDLE;
  - `acc`, `count` and `remaining` to 0;
  - `in_ready`, `out_valid` and `busy` to 0;
  - `out_data` and `out_count` to 0.
- Reset takes effect immediately, regardless of state. A frame in progress is discarded with no output. Leaving reset is synchronous to the next rising edge.
- `start` sampled at edge k:
  - `in_ready`=1 during cycle k+1 (ACCUM), or `out_valid`=1 during k+1 for `len`=0.
- Last beat (or `flush`) at edge m: `out_valid`=1 from cycle m+1.
- Output handshake at edge n: IDLE from cycle n+1, so the earliest next `start` is sampled at edge n+1.
- Minimum frame turnaround for `len`=L with continuous `in_valid` and `out_ready`: L+2 cycles from `start` edge to the next-start edge.
- `in_ready` and `out_valid` are functions of the registered state only, with no combinational path from inputs. `in_ready` never depends on `in_valid`.

## Test plan

- **Reset and empty frame:**
  - Assert `rst_n`=0 mid-ACCUM → all outputs 0 immediately; after release, state is IDLE.
  - Then `start`, `len`=0 → next cycle `out_valid`=1, `out_data`=0x0000, `out_count`=0.
- **Basic frame:** `len`=3, words 0x0001, 0x0100, 0x8000 back-to-back → `out_data`=0x8101, `out_count`=3. `out_valid` rises one cycle after the third beat.
- **Upstream stalls:** `len`=4, `in_valid` toggled 1/0, words 0x000F, 0x00F0, 0x0F00, 0xF000 → `out_data`=0xFFFF, `out_count`=4. No beat is consumed while `in_valid`=0.
- **Flush:**
  - `len`=10, beats 0x0003, 0x0030, then `flush` coincident with a beat of 0x0300 → `out_data`=0x0333, `out_count`=3.
  - `in_ready`=0 the following cycle.
- **Downstream backpressure:** hold `out_ready`=0 for 5 cycles in DONE.
  - `out_data` and `out_count` stay stable.
  - `in_ready` stays 0; words presented are not consumed.
  - `start` pulses are ignored.
  - After `out_ready`=1 → IDLE.
- **Maximum length:** `len`=255, all-zero words except beat 200 = 0x4000 → `out_data`=0x4000, `out_count`=255, with no counter wrap.
